// File: rtl/stage_controller.sv
// Round sequencer for a bank of processing units: loads a syndrome, then
// alternates grow/merge until no odd clusters remain, then peels and hands off.
module stage_controller #(
  parameter int PU_COUNT       = 64,
  parameter int STAGE_WIDTH    = 3,
  parameter int MAX_ITERATIONS = 31,
  parameter int MERGE_QUIET    = 3,
  parameter int ITER_WIDTH     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic [PU_COUNT-1:0]    busy,
  input  logic [PU_COUNT-1:0]    odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic                   overflow
);

  // Handshakes: start is taken only while ready=1 (IDLE); the result is
  // transferred on a cycle where result_valid=1 and result_ready=1, and
  // result_valid then drops on the next cycle. Neither input acts elsewhere.

  localparam int QW = (MERGE_QUIET < 1) ? 1 : $clog2(MERGE_QUIET + 1);
  localparam logic [QW-1:0]         QUIET_MAX = QW'(MERGE_QUIET);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX  = ITER_WIDTH'(MAX_ITERATIONS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GROW   = 3'd2,
    ST_MERGE  = 3'd3,
    ST_PEEL   = 3'd4,
    ST_RESULT = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [QW-1:0]            quiet_q, quiet_d;
  logic [ITER_WIDTH-1:0]    iter_q, iter_d;
  logic                     ovf_q, ovf_d;
  logic                     ready_q;
  logic                     valid_q;
  logic [STAGE_WIDTH-1:0]   stage_q;
  logic                     any_busy;
  logic                     any_odd;

  assign any_busy = |busy;
  assign any_odd  = |odd;

  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          iter_d  = '0;
          ovf_d   = 1'b0;
          quiet_d = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_MERGE;
        quiet_d = '0;
      end
      ST_GROW: begin
        state_d = ST_MERGE;
        quiet_d = '0;
        iter_d  = iter_q + 1'b1;
      end
      ST_MERGE: begin
        // PU busy lags the broadcast stage by a cycle, so the exit decision
        // uses the registered quiet count rather than this cycle's busy.
        if (any_busy) begin
          quiet_d = '0;
        end else if (quiet_q != QUIET_MAX) begin
          quiet_d = quiet_q + 1'b1;
        end
        if (quiet_q == QUIET_MAX) begin
          quiet_d = '0;
          if (any_odd && (iter_q < ITER_MAX)) begin
            state_d = ST_GROW;
          end else begin
            state_d = ST_PEEL;
            if (any_odd) begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      ST_PEEL: begin
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        quiet_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      quiet_q <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == ST_IDLE);
      valid_q <= (state_d == ST_RESULT);
      stage_q <= STAGE_WIDTH'(state_d);
    end
  end

  assign ready           = ready_q;
  assign result_valid    = valid_q;
  assign global_stage    = stage_q;
  assign iteration_count = iter_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_stage_controller.sv
// Directed bench for stage_controller: a vector table for the basic round
// shapes, plus hand-written sequences for overflow, back-pressure and reset.
module tb_stage_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ready;
  logic [63:0] busy;
  logic [63:0] odd;
  logic [2:0]  global_stage;
  logic        result_valid;
  logic        result_ready;
  logic [4:0]  iteration_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  stage_controller #(
    .PU_COUNT(64), .STAGE_WIDTH(3), .MAX_ITERATIONS(3),
    .MERGE_QUIET(3), .ITER_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .busy(busy), .odd(odd), .global_stage(global_stage),
    .result_valid(result_valid), .result_ready(result_ready),
    .iteration_count(iteration_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        rr;
    logic [63:0] busy;
    logic [63:0] odd;
    logic [2:0]  stage;
    logic        rdy;
    logic        vld;
    logic [4:0]  iter;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic rr, input logic [63:0] b,
                     input logic [63:0] o, input logic [2:0] stg,
                     input logic rdy, input logic vld, input logic [4:0] it,
                     input logic ov);
    vec_t v;
    v.start = s; v.rr = rr; v.busy = b; v.odd = o; v.stage = stg;
    v.rdy = rdy; v.vld = vld; v.iter = it; v.ovf = ov;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic wait_stage(input logic [2:0] target, input string name);
    int n = 0;
    while (global_stage !== target && n < 100) begin
      step();
      n++;
    end
    chk(name, n, {63'd0, global_stage === target}, 64'd1);
  endtask

  initial begin
    int grows;
    int n;
    logic peel_ovf;
    reset = 1'b1; start = 1'b0; result_ready = 1'b0; busy = '0; odd = '0;

    // Idle round, busy/odd low: 1, 3 x4, 4, 6, back to 0.
    add(1,0,0,0, 3'd1, 0,0,0,0);
    add(0,0,0,0, 3'd3, 0,0,0,0);
    for (int k = 0; k < 3; k++) add(0,0,0,0, 3'd3, 0,0,0,0);
    add(0,0,0,0, 3'd4, 0,0,0,0);
    add(0,1,0,0, 3'd6, 0,1,0,0);
    add(0,1,0,0, 3'd0, 1,0,0,0);
    add(0,1,0,0, 3'd0, 1,0,0,0);
    // busy[0] on MERGE cycles 2 and 5 stretches MERGE to 9 cycles.
    add(1,0,0,0, 3'd1, 0,0,0,0);
    add(0,0,0,0, 3'd3, 0,0,0,0);
    for (int k = 1; k <= 9; k++)
      add(0,0, (k == 2 || k == 5) ? 64'd1 : 64'd0, 0,
          (k == 9) ? 3'd4 : 3'd3, 0,0,0,0);
    add(0,0,0,0, 3'd6, 0,1,0,0);
    add(0,1,0,0, 3'd0, 1,0,0,0);
    // odd[5] high for two merges: two GROW stages, iteration_count=2.
    add(1,0,0,64'h20, 3'd1, 0,0,0,0);
    add(0,0,0,64'h20, 3'd3, 0,0,0,0);
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 3; k++) add(0,0,0,64'h20, 3'd3, 0,0,5'(g),0);
      add(0,0,0,64'h20, 3'd2, 0,0,5'(g),0);
      add(0,0,0,64'h20, 3'd3, 0,0,5'(g+1),0);
    end
    for (int k = 0; k < 3; k++) add(0,0,0,0, 3'd3, 0,0,2,0);
    add(0,0,0,0, 3'd4, 0,0,2,0);
    add(0,0,0,0, 3'd6, 0,1,2,0);
    add(0,1,0,0, 3'd0, 1,0,2,0);

    step(); step();
    chk("rst_stage", 0, global_stage, 0);
    chk("rst_ready", 0, ready, 1);
    chk("rst_valid", 0, result_valid, 0);
    chk("rst_iter", 0, iteration_count, 0);
    chk("rst_ovf", 0, overflow, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      start = vecs[i].start; result_ready = vecs[i].rr;
      busy = vecs[i].busy; odd = vecs[i].odd;
      step();
      chk("stage", i, global_stage, vecs[i].stage);
      chk("ready", i, ready, vecs[i].rdy);
      chk("valid", i, result_valid, vecs[i].vld);
      chk("iter", i, iteration_count, vecs[i].iter);
      chk("ovf", i, overflow, vecs[i].ovf);
    end
    start = 0; result_ready = 0; busy = '0; odd = '0;

    // odd stuck high with MAX_ITERATIONS=3: overflow after three GROWs.
    odd = '1; start = 1; step(); start = 0;
    chk("ovf_load_stage", 0, global_stage, 1);
    chk("ovf_load_iter", 0, iteration_count, 0);
    grows = 0; n = 0; peel_ovf = 1'b0;
    while (global_stage !== 3'd6 && n < 200) begin
      step();
      if (global_stage == 3'd2) grows++;
      if (global_stage == 3'd4) peel_ovf = overflow;
      n++;
    end
    chk("ovf_reach_result", n, {63'd0, global_stage === 3'd6}, 1);
    chk("ovf_grows", 0, grows, 3);
    chk("ovf_at_peel", 0, peel_ovf, 1);
    chk("ovf_result", 0, overflow, 1);
    chk("ovf_iter", 0, iteration_count, 3);
    result_ready = 1; step(); result_ready = 0;
    chk("ovf_idle_stage", 0, global_stage, 0);
    chk("ovf_idle_hold", 0, overflow, 1);
    start = 1; step(); start = 0;
    chk("ovf_clear_stage", 0, global_stage, 1);
    chk("ovf_clear", 0, overflow, 0);

    // Reset during the second MERGE of this round abandons it.
    wait_stage(3'd2, "wait_grow");
    step();
    chk("r2_merge", 0, global_stage, 3);
    chk("r2_iter", 0, iteration_count, 1);
    step();
    reset = 1; step(); reset = 0;
    chk("mid_rst_stage", 0, global_stage, 0);
    chk("mid_rst_iter", 0, iteration_count, 0);
    chk("mid_rst_valid", 0, result_valid, 0);
    chk("mid_rst_ready", 0, ready, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_idle", k, global_stage, 0);
    end
    odd = '0;

    // Back-pressure in RESULT_VALID; start is ignored while held.
    start = 1; step(); start = 0;
    wait_stage(3'd6, "wait_result");
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      step();
      chk("hold_valid", k, result_valid, 1);
      chk("hold_stage", k, global_stage, 6);
    end
    start = 0; result_ready = 1; step(); result_ready = 0;
    chk("release_stage", 0, global_stage, 0);
    chk("release_ready", 0, ready, 1);

    // Reset wins over start and result_ready in the same cycle.
    reset = 1; start = 1; result_ready = 1; step();
    reset = 0; start = 0; result_ready = 0;
    chk("rst_prio_stage", 0, global_stage, 0);
    chk("rst_prio_ready", 0, ready, 1);
    step();
    chk("rst_prio_after", 0, global_stage, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_controller.md
STAGE_CONTROLLER -- requirements
Module: stage_controller

Interface
REQ-001 SHALL have parameter PU_COUNT, default 64: number of processing units observed.
REQ-002 SHALL have parameter STAGE_WIDTH, default 3: width of the stage code.
REQ-003 SHALL have parameter MAX_ITERATIONS, default 31: grow/merge rounds allowed before abort.
REQ-004 SHALL have parameter MERGE_QUIET, default 3: consecutive all-idle MERGE cycles that end a merge.
REQ-005 SHALL have parameter ITER_WIDTH, default 5, holding MAX_ITERATIONS.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1: new syndrome round requested.
REQ-009 SHALL have port ready, output, 1: controller idle and accepting start.
REQ-010 SHALL have port busy, input, PU_COUNT: per-PU busy flags.
REQ-011 SHALL have port odd, input, PU_COUNT: per-PU odd-cluster flags.
REQ-012 SHALL have port global_stage, output, STAGE_WIDTH: stage broadcast to all PUs.
REQ-013 SHALL have port result_valid, output, 1: peeling result present on PU error outputs.
REQ-014 SHALL have port result_ready, input, 1: downstream consumer accepts the result.
REQ-015 SHALL have port iteration_count, output, ITER_WIDTH: completed grow rounds of the current round.
REQ-016 SHALL have port overflow, output, 1: round aborted at MAX_ITERATIONS.

Function
REQ-017 SHALL use stage codes IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3, PEELING=4, RESULT_VALID=6; global_stage SHALL be a registered copy of the FSM state.
REQ-018 SHALL assert ready only in IDLE.
REQ-019 IDLE SHALL move to MEASUREMENT_LOADING on the cycle after start=1 is seen in IDLE; start outside IDLE SHALL be ignored.
REQ-020 MEASUREMENT_LOADING SHALL last exactly 1 cycle, then MERGE, with iteration_count cleared to 0 and overflow cleared.
REQ-021 GROW SHALL last exactly 1 cycle, then MERGE; iteration_count SHALL increment on leaving GROW.
REQ-022 On MERGE entry, the quiet counter SHALL clear. Each MERGE cycle with |busy=0 SHALL increment it. Any cycle with |busy=1 SHALL clear it.
REQ-023 MERGE SHALL remain active for at least MERGE_QUIET+1 cycles, since PU busy is registered one cycle behind the stage.
REQ-024 MERGE SHALL exit when the quiet counter reaches MERGE_QUIET: to GROW if |odd=1 and iteration_count<MAX_ITERATIONS; to PEELING if |odd=0.
REQ-025 If |odd=1 and iteration_count==MAX_ITERATIONS at MERGE exit, overflow SHALL be set and held until the next MEASUREMENT_LOADING, and the FSM SHALL go to PEELING.
REQ-026 PEELING SHALL last exactly 1 cycle, then RESULT_VALID.
REQ-027 result_valid SHALL be 1 only in RESULT_VALID; RESULT_VALID SHALL hold until result_ready=1, then move to IDLE on the next cycle.
REQ-028 result_ready=1 outside RESULT_VALID SHALL have no effect.
REQ-029 The quiet counter SHALL saturate and SHALL be sized $clog2(MERGE_QUIET+1) bits.
REQ-030 odd and busy SHALL be sampled raw, with no synchronisation, since they share clk.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, global_stage=0, ready=1 the following cycle, result_valid=0, iteration_count=0, overflow=0, quiet counter=0.
REQ-032 Reset mid-round, in any state, SHALL abandon the round with no further stages issued.
REQ-033 Reset SHALL take priority over start and result_ready arriving in the same cycle.

Verification
REQ-034 Single-cycle start in IDLE with busy=0 and odd=0 SHALL give global_stage 0 -> 1 -> 3 (4 cycles) -> 4 -> 6; with result_ready=1 the FSM SHALL return to 0 and iteration_count SHALL be 0.
REQ-035 With odd[5]=1 for the first two merges, then 0, the stage sequence SHALL be 1,3..,2,3..,2,3..,4,6, with iteration_count=2 at RESULT_VALID.
REQ-036 With busy[0] pulsed 1 on MERGE cycles 2 and 5, MERGE SHALL last 9 cycles, exiting after 3 quiet cycles following cycle 5.
REQ-037 With odd stuck at 1 and MAX_ITERATIONS=3, there SHALL be 3 GROW stages, then overflow=1, PEELING and RESULT_VALID, and overflow SHALL clear on the next MEASUREMENT_LOADING.
REQ-038 With result_ready=0 for 10 cycles in RESULT_VALID, result_valid SHALL stay 1 and start SHALL be ignored; result_ready=1 SHALL return the FSM to IDLE in 1 cycle.
REQ-039 Reset asserted during MERGE of round 2 SHALL give global_stage=0, iteration_count=0, result_valid=0 the next cycle.
